// File: rtl/output_drain_pkg.sv
// Shared defaults, FSM encodings and a width helper for the output drain block.
package output_drain_pkg;

    localparam int DEF_GROUP_SIZE      = 4;
    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_NUM_OUTPUTS     = 9;
    localparam int DEF_LOG_MAX_ADDRESS = 12;
    localparam int DEF_LOG_MAX_READS   = 12;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Channel index width; never zero so a single memory still gets a 1-bit index.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/output_drain_if.sv
// Memory-side read bus and outgoing word stream of the output drain.
interface output_drain_if #(
    parameter int GROUP_SIZE      = output_drain_pkg::DEF_GROUP_SIZE,
    parameter int DATA_WIDTH      = output_drain_pkg::DEF_DATA_WIDTH,
    parameter int NUM_OUTPUTS     = output_drain_pkg::DEF_NUM_OUTPUTS,
    parameter int LOG_MAX_ADDRESS = output_drain_pkg::DEF_LOG_MAX_ADDRESS
);
    localparam int CH_W = output_drain_pkg::chan_width(NUM_OUTPUTS);

    logic [NUM_OUTPUTS-1:0]                       mem_read;
    logic [NUM_OUTPUTS*LOG_MAX_ADDRESS-1:0]       mem_addr;
    logic [NUM_OUTPUTS*GROUP_SIZE*DATA_WIDTH-1:0] mem_data;
    logic [NUM_OUTPUTS-1:0]                       mem_valid;
    logic [GROUP_SIZE*DATA_WIDTH-1:0]             out_data;
    logic [CH_W-1:0]                              out_channel;
    logic [LOG_MAX_ADDRESS-1:0]                   out_addr;
    logic                                         out_valid;
    logic                                         out_ready;

    modport master (
        output mem_read, mem_addr, out_data, out_channel, out_addr, out_valid,
        input  mem_data, mem_valid, out_ready
    );

    modport slave (
        input  mem_read, mem_addr, out_data, out_channel, out_addr, out_valid,
        output mem_data, mem_valid, out_ready
    );

endinterface

// File: rtl/drain_fifo.sv
// Two-entry FIFO holding returned words until the stream consumer accepts them.
module drain_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end

    // Present zeros while empty so the stream fields read as zero after reset.
    assign o_dout = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/output_drain.sv
// Reads num_reads words from each output memory, address-major, and streams them out.
module output_drain
    import output_drain_pkg::*;
#(
    parameter int GROUP_SIZE      = DEF_GROUP_SIZE,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int NUM_OUTPUTS     = DEF_NUM_OUTPUTS,
    parameter int LOG_MAX_ADDRESS = DEF_LOG_MAX_ADDRESS,
    parameter int LOG_MAX_READS   = DEF_LOG_MAX_READS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       configure,
    input  logic [LOG_MAX_ADDRESS-1:0] start_address,
    input  logic [LOG_MAX_READS-1:0]   num_reads,
    output logic                       busy,
    output logic                       done,
    output_drain_if.master             drain_bus
);
    localparam int WORD_W = GROUP_SIZE * DATA_WIDTH;
    localparam int CH_W   = chan_width(NUM_OUTPUTS);
    localparam int CNT_W  = LOG_MAX_READS + CH_W;
    localparam int ENT_W  = WORD_W + CH_W + LOG_MAX_ADDRESS;

    logic [1:0]                 r_state;
    logic [LOG_MAX_ADDRESS-1:0] r_addr;
    logic [CH_W-1:0]            r_chan;
    logic [CNT_W-1:0]           r_left;
    logic                       r_inflight;
    logic [CH_W-1:0]            r_inflight_chan;
    logic [LOG_MAX_ADDRESS-1:0] r_inflight_addr;

    logic [WORD_W-1:0]          w_mem_words [NUM_OUTPUTS];
    logic [ENT_W-1:0]           w_push_entry;
    logic [ENT_W-1:0]           w_head;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_pop;
    logic                       w_ret;
    logic                       w_issue;
    logic [1:0]                 w_occ;
    logic [1:0]                 w_level;

    generate
        for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_mem
            assign drain_bus.mem_read[gi] = w_issue && (r_chan == CH_W'(gi));
            assign drain_bus.mem_addr[gi*LOG_MAX_ADDRESS +: LOG_MAX_ADDRESS] = r_addr;
            assign w_mem_words[gi] = drain_bus.mem_data[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign w_pop   = !w_empty && drain_bus.out_ready;
    assign w_ret   = r_inflight && drain_bus.mem_valid[r_inflight_chan];
    assign w_occ   = w_full ? 2'd2 : (w_empty ? 2'd0 : 2'd1);
    // Occupancy at the end of this cycle; a new read may issue only if its word is sure to fit.
    assign w_level = w_occ + {1'b0, w_ret} - {1'b0, w_pop};
    assign w_issue = (r_state == S_ISSUE) && (!r_inflight || w_ret) && (w_level < 2'd2);

    assign w_push_entry = {w_mem_words[r_inflight_chan], r_inflight_chan, r_inflight_addr};

    drain_fifo #(
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_ret),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {drain_bus.out_data, drain_bus.out_channel, drain_bus.out_addr} = w_head;
    assign drain_bus.out_valid = !w_empty;
    assign busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_chan          <= '0;
            r_left          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_chan <= '0;
            r_inflight_addr <= '0;
        end else begin
            r_inflight <= w_issue || (r_inflight && !w_ret);
            if (w_issue) begin
                r_inflight_chan <= r_chan;
                r_inflight_addr <= r_addr;
            end
            case (r_state)
                S_IDLE: begin
                    if (configure) begin
                        r_addr  <= start_address;
                        r_chan  <= '0;
                        r_left  <= CNT_W'(num_reads) * CNT_W'(NUM_OUTPUTS);
                        r_state <= (num_reads == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_left <= r_left - CNT_W'(1);
                        if (r_chan == CH_W'(NUM_OUTPUTS - 1)) begin
                            r_chan <= '0;
                            r_addr <= r_addr + LOG_MAX_ADDRESS'(1);
                        end else begin
                            r_chan <= r_chan + CH_W'(1);
                        end
                        if (r_left == CNT_W'(1)) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_inflight && (w_level == 2'd0)) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_drain.sv
// Directed bench for output_drain with a scoreboard of expected stream words.
module tb_output_drain;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  chan;
        logic [11:0] addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        configure;
    logic [11:0] start_address;
    logic [11:0] num_reads;
    logic        busy;
    logic        done;
    logic        out_ready;
    logic [8:0]  force_valid;
    logic [8:0]  mem_valid_r;
    logic [287:0] mem_data_r;

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_words = 0;
    int   done_cnt = 0;
    int   busy_cnt = 0;
    int   read_cnt = 0;
    logic prev_stall = 1'b0;
    ent_t prev_ent;
    ent_t q[$];

    output_drain_if drain_bus ();

    output_drain dut (
        .clk           (clk),
        .rst           (rst),
        .configure     (configure),
        .start_address (start_address),
        .num_reads     (num_reads),
        .busy          (busy),
        .done          (done),
        .drain_bus     (drain_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int m, input int a);
        return {16'(m), 16'(a)};
    endfunction

    // One-cycle-latency memory model shared by all nine output memories.
    always @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            mem_valid_r[i] <= drain_bus.mem_read[i];
            if (drain_bus.mem_read[i])
                mem_data_r[i*32 +: 32] <= word_of(i, int'(drain_bus.mem_addr[i*12 +: 12]));
        end
    end

    assign drain_bus.mem_data  = mem_data_r;
    assign drain_bus.mem_valid = mem_valid_r | force_valid;
    assign drain_bus.out_ready = out_ready;

    task automatic expect_seq(input int start, input int n);
        for (int a = 0; a < n; a++) begin
            for (int m = 0; m < 9; m++) begin
                ent_t e;
                e.data = word_of(m, (start + a) % 4096);
                e.chan = 4'(m);
                e.addr = 12'((start + a) % 4096);
                q.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        ent_t cur;
        ent_t exp_e;
        cur = {drain_bus.out_data, drain_bus.out_channel, drain_bus.out_addr};
        if (rst) begin
            n_chk++;
            assert ($onehot0(drain_bus.mem_read) === 1'b1) else begin
                n_fail++; $error("FAIL onehot mem_read=%b required one-hot or zero", drain_bus.mem_read);
            end
            if (prev_stall) begin
                n_chk++;
                assert ({drain_bus.out_valid, cur} === {1'b1, prev_ent}) else begin
                    n_fail++; $error("FAIL stall_hold got v=%0b %h required v=1 %h", drain_bus.out_valid, cur, prev_ent);
                end
            end
            if (drain_bus.out_valid && out_ready) begin
                n_words++;
                n_chk++;
                assert (q.size() != 0) else begin
                    n_fail++; $error("FAIL extra_word got %h required none", cur);
                end
                if (q.size() != 0) begin
                    exp_e = q.pop_front();
                    n_chk++;
                    assert (cur === exp_e) else begin
                        n_fail++; $error("FAIL word got %h required %h", cur, exp_e);
                    end
                end
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (|drain_bus.mem_read) read_cnt++;
            prev_stall = drain_bus.out_valid && !out_ready;
            prev_ent   = cur;
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_configure(input int start, input int n);
        start_address = 12'(start);
        num_reads     = 12'(n);
        configure     = 1'b1;
        step();
        configure     = 1'b0;
    endtask

    // Runs until done pulses; mode 1 toggles out_ready 1,0,0,1; cfg2_at injects a stray configure.
    task automatic run_drain(input int mode, input int budget, input int cfg2_at);
        int c;
        int d0;
        d0 = done_cnt;
        c  = 0;
        while (done_cnt == d0 && c < budget) begin
            out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (c == cfg2_at) begin
                start_address = 12'd100;
                num_reads     = 12'd2;
                configure     = 1'b1;
            end
            step();
            configure = 1'b0;
            c++;
        end
        n_chk++;
        assert (done_cnt != d0) else begin
            n_fail++; $error("FAIL timeout got no done within %0d cycles required done", budget);
        end
        out_ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic check_run(input string tag, input int w0, input int d0, input int nw);
        n_chk++;
        assert ((n_words - w0) === nw) else begin
            n_fail++; $error("FAIL %s_words got %0d required %0d", tag, n_words - w0, nw);
        end
        n_chk++;
        assert (q.size() === 0) else begin
            n_fail++; $error("FAIL %s_left got %0d required 0", tag, q.size());
        end
        n_chk++;
        assert ((done_cnt - d0) === 1) else begin
            n_fail++; $error("FAIL %s_done got %0d required 1", tag, done_cnt - d0);
        end
    endtask

    initial begin
        int w0, d0, b0, r0, c;
        rst = 1'b0; configure = 1'b0; start_address = '0; num_reads = '0;
        out_ready = 1'b1; force_valid = '0;
        @(posedge clk); #1;
        repeat (3) step();

        n_chk++; assert (drain_bus.mem_read === 9'd0) else begin n_fail++; $error("FAIL rst_mem_read got %b required 0", drain_bus.mem_read); end
        n_chk++; assert (drain_bus.mem_addr === 108'd0) else begin n_fail++; $error("FAIL rst_mem_addr got %h required 0", drain_bus.mem_addr); end
        n_chk++; assert (drain_bus.out_valid === 1'b0) else begin n_fail++; $error("FAIL rst_out_valid got %b required 0", drain_bus.out_valid); end
        n_chk++; assert (drain_bus.out_data === 32'd0) else begin n_fail++; $error("FAIL rst_out_data got %h required 0", drain_bus.out_data); end
        n_chk++; assert (drain_bus.out_channel === 4'd0) else begin n_fail++; $error("FAIL rst_out_channel got %h required 0", drain_bus.out_channel); end
        n_chk++; assert (drain_bus.out_addr === 12'd0) else begin n_fail++; $error("FAIL rst_out_addr got %h required 0", drain_bus.out_addr); end
        n_chk++; assert ({busy, done} === 2'b00) else begin n_fail++; $error("FAIL rst_busy_done got %b required 00", {busy, done}); end

        rst = 1'b1;
        step();

        // Full drain with the consumer always ready.
        w0 = n_words; d0 = done_cnt; b0 = busy_cnt;
        expect_seq(0, 4);
        do_configure(0, 4);
        n_chk++; assert (busy === 1'b1) else begin n_fail++; $error("FAIL busy_after_cfg got %b required 1", busy); end
        run_drain(0, 200, -1);
        check_run("full", w0, d0, 36);
        n_chk++;
        assert (((busy_cnt - b0) >= 37) && ((busy_cnt - b0) <= 40)) else begin
            n_fail++; $error("FAIL full_busy_cycles got %0d required 37..40", busy_cnt - b0);
        end
        $display("txn full drain: %0d words, %0d busy cycles", n_words - w0, busy_cnt - b0);

        // Stray valid on an idle memory must not create a word.
        force_valid = 9'h1ff;
        step();
        force_valid = '0;
        repeat (3) step();
        $display("txn idle stray mem_valid: words now %0d", n_words);

        // Back-pressured drain.
        w0 = n_words; d0 = done_cnt;
        expect_seq(0, 4);
        do_configure(0, 4);
        run_drain(1, 400, -1);
        check_run("stall", w0, d0, 36);
        $display("txn stalled drain: %0d words", n_words - w0);

        // Address wrap at the top of the address space.
        w0 = n_words; d0 = done_cnt;
        expect_seq(4094, 3);
        do_configure(4094, 3);
        run_drain(0, 200, -1);
        check_run("wrap", w0, d0, 27);
        $display("txn wrap drain: %0d words", n_words - w0);

        // Zero-length request.
        d0 = done_cnt; b0 = busy_cnt; r0 = read_cnt;
        do_configure(0, 0);
        n_chk++; assert ({done, busy} === 2'b10) else begin n_fail++; $error("FAIL zero_done_busy got %b required 10", {done, busy}); end
        repeat (4) step();
        n_chk++; assert ((read_cnt - r0) === 0) else begin n_fail++; $error("FAIL zero_reads got %0d required 0", read_cnt - r0); end
        n_chk++; assert ((busy_cnt - b0) === 0) else begin n_fail++; $error("FAIL zero_busy got %0d required 0", busy_cnt - b0); end
        n_chk++; assert ((done_cnt - d0) === 1) else begin n_fail++; $error("FAIL zero_done_cnt got %0d required 1", done_cnt - d0); end
        $display("txn zero-length: done pulses %0d", done_cnt - d0);

        // Reset after ten words, then a fresh one-address drain.
        w0 = n_words;
        expect_seq(0, 4);
        do_configure(0, 4);
        c = 0;
        out_ready = 1'b1;
        while ((n_words - w0) < 10 && c < 100) begin
            step();
            c++;
        end
        n_chk++; assert ((n_words - w0) === 10) else begin n_fail++; $error("FAIL pre_reset_words got %0d required 10", n_words - w0); end
        rst = 1'b0;
        q.delete();
        step();
        rst = 1'b1;
        force_valid = 9'h1ff;
        step();
        force_valid = '0;
        step();
        n_chk++; assert ({busy, drain_bus.out_valid} === 2'b00) else begin n_fail++; $error("FAIL post_reset_state got %b required 00", {busy, drain_bus.out_valid}); end
        w0 = n_words; d0 = done_cnt;
        expect_seq(0, 1);
        do_configure(0, 1);
        run_drain(0, 100, -1);
        check_run("after_reset", w0, d0, 9);
        $display("txn reset mid-drain then new drain: %0d words", n_words - w0);

        // Configure while busy is ignored.
        w0 = n_words; d0 = done_cnt;
        expect_seq(0, 4);
        do_configure(0, 4);
        run_drain(0, 200, 10);
        check_run("ignored_cfg", w0, d0, 36);
        $display("txn configure while busy: %0d words", n_words - w0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/output_drain.md
OUTPUT_DRAIN -- requirements
Module: output_drain

Interface
REQ-001 Parameter GROUP_SIZE, 4, activation values per memory word.
REQ-002 Parameter DATA_WIDTH, 8, bits per activation value.
REQ-003 Parameter NUM_OUTPUTS, 9, number of output memories drained.
REQ-004 Parameter LOG_MAX_ADDRESS, 12, memory address width.
REQ-005 Parameter LOG_MAX_READS, 12, width of the address-count field.
REQ-006 clk  in  1  single clock; all logic rising-edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 configure  in  1  one-cycle pulse; latches start_address and num_reads, starts drain.
REQ-009 start_address  in  LOG_MAX_ADDRESS  first address read in every output memory.
REQ-010 num_reads  in  LOG_MAX_READS  addresses read per memory.
REQ-011 mem_read  out  NUM_OUTPUTS  per-memory read strobe, one-hot or zero.
REQ-012 mem_addr  out  NUM_OUTPUTS*LOG_MAX_ADDRESS  per-memory read address, slice i for memory i.
REQ-013 mem_data  in  NUM_OUTPUTS*GROUP_SIZE*DATA_WIDTH  per-memory read data.
REQ-014 mem_valid  in  NUM_OUTPUTS  per-memory read-data valid.
REQ-015 out_data  out  GROUP_SIZE*DATA_WIDTH  streamed word.
REQ-016 out_channel  out  clog2(NUM_OUTPUTS)  source memory index of out_data.
REQ-017 out_addr  out  LOG_MAX_ADDRESS  source address of out_data.
REQ-018 out_valid  out  1  stream valid.
REQ-019 out_ready  in  1  stream ready; a transfer occurs when out_valid and out_ready are both high.
REQ-020 busy  out  1  high from the cycle after an accepted configure until done.
REQ-021 done  out  1  one-cycle pulse after the last word transfers.

Function
REQ-022 The read order SHALL be address-major, memory-minor: (a0,m0),(a0,m1)..(a0,mN-1),(a1,m0)...
REQ-023 Addresses SHALL run start_address .. start_address+num_reads-1 and wrap modulo 2^LOG_MAX_ADDRESS.
REQ-024 Memory read latency SHALL be one cycle: data for a read issued in cycle t is sampled when mem_valid[i] is high in cycle t+1.
REQ-025 The stream SHALL be buffered in a 2-entry FIFO; a read SHALL issue only when FIFO occupancy plus in-flight reads is less than 2.
REQ-026 The stream SHALL sustain one word per cycle when out_ready is held high.
REQ-027 mem_valid on a memory with no outstanding read SHALL be ignored.
REQ-028 out_data, out_channel and out_addr SHALL be held stable while out_valid is high and out_ready is low.
REQ-029 The state machine SHALL have states IDLE -> ISSUE (on configure with num_reads>0) -> DRAIN (last read issued) -> DONE (FIFO empty, no read in flight) -> IDLE.
REQ-030 A configure with num_reads=0 SHALL go IDLE -> DONE directly: done pulses 1 cycle later and no read issues.
REQ-031 configure SHALL be ignored outside IDLE.
REQ-032 The issue counters SHALL count exactly num_reads*NUM_OUTPUTS reads; the count SHALL be stored at LOG_MAX_READS+clog2(NUM_OUTPUTS) bits without overflow.

Reset
REQ-033 While rst=0 at a clock edge: mem_read=0, mem_addr=0, out_valid=0, out_data=0, out_channel=0, out_addr=0, busy=0, done=0, FIFO empty, state IDLE.
REQ-034 Reset mid-drain SHALL discard the FIFO contents and any in-flight read; mem_valid in the cycle after reset release SHALL be ignored.

Structure
REQ-035 Default parameter values and state encodings SHALL live in the shared RTLinf package or include file.
REQ-036 The 2-entry FIFO SHALL be a sub-module, drain_fifo, with push/pop/full/empty.

Verification
REQ-037 Each memory i preloaded with word {i,a} at addresses 0..3; start=0, num_reads=4, out_ready=1 -> 36 words in order (a0,m0)..(a3,m8), busy for 37+ cycles, a single done pulse.
REQ-038 Same preload; out_ready toggles 1,0,0,1 repeating -> identical 36-word sequence, no drop or duplicate, data stable while stalled.
REQ-039 start=4094, num_reads=3 -> addresses 4094, 4095, 0 per memory; 27 words.
REQ-040 num_reads=0 -> no mem_read asserted; done pulses 1 cycle after configure; busy stays 0.
REQ-041 rst=0 for one cycle after 10 words, then a new configure (start=0, num_reads=1) -> exactly 9 words; no stale word appears.
REQ-042 configure pulsed while busy with start=100 -> ignored; the original sequence completes unchanged.
